// File: rtl/valu_pipe.sv
// ---------------------------------------------------------------------------
// valu_pipe -- two-stage, LANES-wide vector integer ALU with valid/ready
// handshakes on both sides.
//
// Stage S1 registers the operand bundle (rs1, rs2, opcode, lane mask).
// Stage S2 registers the per-lane result and flags computed from S1.
// With out_ready held high, the pipeline accepts and returns one bundle
// per cycle. A bundle accepted in cycle c is presented on out_valid in
// cycle c+2.
//
// Optional feature:
//   VALU_PIPE_SAT_EN  -- when defined, ADD/SUB lanes that overflow return
//                        the signed saturation value instead of the wrapped
//                        sum. The overflow flag is still set.
//
// Parameters:
//   DATA_WIDTH  lane width in bits (8..64)
//   LANES       number of parallel lanes (1..16)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid     operand bundle valid
//   in_ready     bundle accepted this cycle (no combinational path from in_valid)
//   rs1_data_i   operand A, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rs2_data_i   operand B, same packing
//   alu_op_in    4-bit opcode (ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
//                BEQ BNE BLT BGE BLTU BGEU)
//   lane_mask_i  1 = lane active
//   out_valid    result bundle valid
//   out_ready    consumer accepts result
//   alu_res_o    per-lane result
//   cond_o       per-lane compare outcome for branch opcodes, else 0
//   zero_o       per-lane zero flag (cond for branch opcodes)
//   negative_o   per-lane result MSB
//   overflow_o   per-lane signed overflow for ADD/SUB
//   ovf_count_o  saturating count of overflowing lanes delivered downstream
// ---------------------------------------------------------------------------
module valu_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] rs1_data_i,
   input  logic [LANES*DATA_WIDTH-1:0] rs2_data_i,
   input  logic [3:0]                  alu_op_in,
   input  logic [LANES-1:0]            lane_mask_i,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] alu_res_o,
   output logic [LANES-1:0]            cond_o,
   output logic [LANES-1:0]            zero_o,
   output logic [LANES-1:0]            negative_o,
   output logic [LANES-1:0]            overflow_o,
   output logic [15:0]                 ovf_count_o
);

   localparam int SHW = $clog2(DATA_WIDTH);
   localparam int VW  = LANES * DATA_WIDTH;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLL  = 4'd2,
      OP_SLT  = 4'd3,
      OP_SLTU = 4'd4,
      OP_XOR  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_OR   = 4'd8,
      OP_AND  = 4'd9,
      OP_BEQ  = 4'd10,
      OP_BNE  = 4'd11,
      OP_BLT  = 4'd12,
      OP_BGE  = 4'd13,
      OP_BLTU = 4'd14,
      OP_BGEU = 4'd15
   } alu_op_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] res;
      logic                  cond;
      logic                  zero;
      logic                  neg;
      logic                  ovf;
   } lane_out_t;

   // ------------------------------------------------------------------------
   // Single-lane datapath. Pure function of the S1 operands so the whole
   // compute stage is one combinational cloud between S1 and S2.
   // ------------------------------------------------------------------------
   function automatic lane_out_t lane_calc(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input alu_op_e               op,
      input logic                  active
   );
      lane_out_t             o;
      logic [DATA_WIDTH-1:0] sum;
      logic [DATA_WIDTH-1:0] diff;
      logic [DATA_WIDTH-1:0] r;
      logic [SHW-1:0]        sh;
      logic                  lt_s;
      logic                  lt_u;
      logic                  c;
      logic                  v;

      sum  = a + b;
      diff = a - b;
      sh   = b[SHW-1:0];
      lt_s = $signed(a) < $signed(b);
      lt_u = a < b;
      r    = '0;
      c    = 1'b0;
      v    = 1'b0;

      unique case (op)
         OP_ADD: begin
            r = sum;
            // Same-sign operands producing an opposite-sign sum.
            v = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_SUB: begin
            r = diff;
            // Opposite-sign operands where the difference loses a's sign.
            v = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
         end
         OP_SLL:  r = a << sh;
         OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, lt_s};
         OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, lt_u};
         OP_XOR:  r = a ^ b;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = $signed(a) >>> sh;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         // Equality branches report the difference so software can reuse it.
         OP_BEQ: begin
            c = (a == b);
            r = diff;
         end
         OP_BNE: begin
            c = (a != b);
            r = diff;
         end
         OP_BLT: begin
            c = lt_s;
            r = {{(DATA_WIDTH-1){1'b0}}, c};
         end
         OP_BGE: begin
            c = !lt_s;
            r = {{(DATA_WIDTH-1){1'b0}}, c};
         end
         OP_BLTU: begin
            c = lt_u;
            r = {{(DATA_WIDTH-1){1'b0}}, c};
         end
         OP_BGEU: begin
            c = !lt_u;
            r = {{(DATA_WIDTH-1){1'b0}}, c};
         end
         default: r = '0;
      endcase

`ifdef VALU_PIPE_SAT_EN
      // Overflow direction always follows a's sign for both ADD and SUB:
      // a negative a can only overflow past the most negative value.
      if (v) begin
         r = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
`else
      // Wrapping arithmetic: the modulo-2^DATA_WIDTH result stands as is.
`endif

      o.res  = r;
      o.cond = c;
      o.neg  = r[DATA_WIDTH-1];
      o.ovf  = v;
      // Branch opcodes report the relation on zero, like a flags register
      // after a compare-and-branch.
      o.zero = (op >= OP_BEQ) ? c : (r == '0);

      // A masked lane passes rs1 through untouched and raises nothing.
      if (!active) begin
         o.res  = a;
         o.cond = 1'b0;
         o.zero = 1'b0;
         o.neg  = 1'b0;
         o.ovf  = 1'b0;
      end
      return o;
   endfunction

   // ------------------------------------------------------------------------
   // Stage S1: operand registers
   // ------------------------------------------------------------------------
   logic              s1_valid;
   logic [VW-1:0]     s1_rs1;
   logic [VW-1:0]     s1_rs2;
   alu_op_e           s1_op;
   logic [LANES-1:0]  s1_mask;

   logic              s1_adv;
   logic              in_fire;
   logic              out_fire;

   // S1 may move forward when S2 is empty or is being drained this cycle.
   // in_ready depends only on register state and out_ready, never in_valid.
   assign s1_adv   = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s1_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_ff @(posedge clk) begin
      // NOTE: Sequential state uses non-blocking assignments so every
      // register samples pre-edge values and stage order does not matter.
      if (rst) begin
         // NOTE: Operand and result registers are reset along with the valid
         // bits; outputs must read zero after reset and this keeps unknowns
         // out of the datapath.
         s1_valid <= 1'b0;
         s1_rs1   <= '0;
         s1_rs2   <= '0;
         s1_op    <= OP_ADD;
         s1_mask  <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_rs1   <= rs1_data_i;
         s1_rs2   <= rs2_data_i;
         s1_op    <= alu_op_e'(alu_op_in);
         s1_mask  <= lane_mask_i;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Compute: all lanes in parallel from S1 contents
   // ------------------------------------------------------------------------
   lane_out_t lane_out [LANES];

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_out[k] = lane_calc(s1_rs1[k*DATA_WIDTH +: DATA_WIDTH],
                                 s1_rs2[k*DATA_WIDTH +: DATA_WIDTH],
                                 s1_op,
                                 s1_mask[k]);
      end
   end

   // ------------------------------------------------------------------------
   // Overflow counter increment: popcount of the delivered overflow flags
   // ------------------------------------------------------------------------
   logic [4:0]  ovf_pop;
   logic [16:0] ovf_sum;

   always_comb begin
      // NOTE: Defaults are assigned before the loop so no path leaves a
      // combinational variable unassigned and no latch is inferred.
      ovf_pop = '0;
      for (int k = 0; k < LANES; k++) begin
         ovf_pop = ovf_pop + 5'(overflow_o[k]);
      end
      ovf_sum = {1'b0, ovf_count_o} + {12'd0, ovf_pop};
   end

   // ------------------------------------------------------------------------
   // Stage S2: result registers drive the outputs directly
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         alu_res_o   <= '0;
         cond_o      <= '0;
         zero_o      <= '0;
         negative_o  <= '0;
         overflow_o  <= '0;
         ovf_count_o <= '0;
      end else begin
         if (s1_adv) begin
            out_valid <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
               alu_res_o[k*DATA_WIDTH +: DATA_WIDTH] <= lane_out[k].res;
               cond_o[k]     <= lane_out[k].cond;
               zero_o[k]     <= lane_out[k].zero;
               negative_o[k] <= lane_out[k].neg;
               overflow_o[k] <= lane_out[k].ovf;
            end
         end else if (out_ready) begin
            // Drained with nothing behind it; data is left as is, only the
            // valid bit drops.
            out_valid <= 1'b0;
         end

         // Counted when the bundle leaves, so a stalled bundle is counted
         // once and a reset-discarded one never.
         if (out_fire) begin
            ovf_count_o <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
         end
      end
   end

endmodule

// File: tb/tb_valu_pipe.sv
module tb_valu_pipe;

   localparam int DW = 32;
   localparam int L  = 4;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [L*DW-1:0] rs1_data_i;
   logic [L*DW-1:0] rs2_data_i;
   logic [3:0]     alu_op_in;
   logic [L-1:0]   lane_mask_i;
   logic           out_valid;
   logic           out_ready;
   logic [L*DW-1:0] alu_res_o;
   logic [L-1:0]   cond_o;
   logic [L-1:0]   zero_o;
   logic [L-1:0]   negative_o;
   logic [L-1:0]   overflow_o;
   logic [15:0]    ovf_count_o;

   int checks   = 0;
   int failures = 0;
   int exp_ovf  = 0;

   valu_pipe #(.DATA_WIDTH(DW), .LANES(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .alu_op_in   (alu_op_in),
      .lane_mask_i (lane_mask_i),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .alu_res_o   (alu_res_o),
      .cond_o      (cond_o),
      .zero_o      (zero_o),
      .negative_o  (negative_o),
      .overflow_o  (overflow_o),
      .ovf_count_o (ovf_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3,
                          SLTU = 4'd4, SRL = 4'd6, SRA = 4'd7, AND = 4'd9,
                          BNE = 4'd11, BLT = 4'd12, BGEU = 4'd15;

   function automatic logic [L*DW-1:0] pack4(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one bundle for exactly one cycle (caller guarantees in_ready).
   task automatic issue(input logic [3:0] op, input logic [L*DW-1:0] a,
                        input logic [L*DW-1:0] b, input logic [L-1:0] m);
      alu_op_in   = op;
      rs1_data_i  = a;
      rs2_data_i  = b;
      lane_mask_i = m;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_op_in = '0; rs1_data_i = '0; rs2_data_i = '0; lane_mask_i = '0;
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (alu_res_o !== '0) begin failures++; $display("FAIL reset_res got=%h exp=0", alu_res_o); end
      checks++; if ({cond_o, zero_o, negative_o, overflow_o} !== 16'h0) begin failures++;
         $display("FAIL reset_flags got=%h exp=0", {cond_o, zero_o, negative_o, overflow_o}); end
      checks++; if (ovf_count_o !== 16'h0) begin failures++; $display("FAIL reset_ovf_count got=%h exp=0", ovf_count_o); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_add_overflow();
      logic [L*DW-1:0] exp_res;
      logic [L-1:0]    exp_neg;
`ifdef VALU_PIPE_SAT_EN
      exp_res = pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0);
      exp_neg = 4'b0000;
`else
      exp_res = pack4(32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0);
      exp_neg = 4'b0001;
`endif
      // Lane 1 would overflow too but is masked off.
      issue(ADD, pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0), pack4(1, 1, 0, 0), 4'b0001);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_latency_early got=%b exp=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency got=%b exp=1", out_valid); end
      checks++; if (alu_res_o !== exp_res) begin failures++; $display("FAIL add_res got=%h exp=%h", alu_res_o, exp_res); end
      checks++; if (overflow_o !== 4'b0001) begin failures++; $display("FAIL add_ovf got=%b exp=0001", overflow_o); end
      checks++; if (negative_o !== exp_neg) begin failures++; $display("FAIL add_neg got=%b exp=%b", negative_o, exp_neg); end
      checks++; if (zero_o !== 4'b0000) begin failures++; $display("FAIL add_zero got=%b exp=0000", zero_o); end
      tick();
      exp_ovf += 1;
      checks++; if (ovf_count_o !== 16'(exp_ovf)) begin failures++; $display("FAIL add_ovf_count got=%0d exp=%0d", ovf_count_o, exp_ovf); end
   endtask

   task automatic test_blt();
      issue(BLT, pack4(32'hFFFFFFFF, 5, 3, 0), pack4(0, 2, 3, 1), 4'b1111);
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL blt_valid got=%b exp=1", out_valid); end
      checks++; if (cond_o !== 4'b1001) begin failures++; $display("FAIL blt_cond got=%b exp=1001", cond_o); end
      checks++; if (zero_o !== 4'b1001) begin failures++; $display("FAIL blt_zero got=%b exp=1001", zero_o); end
      checks++; if (alu_res_o !== pack4(1, 0, 0, 1)) begin failures++; $display("FAIL blt_res got=%h", alu_res_o); end
      tick();
   endtask

   task automatic test_sra();
      logic [L*DW-1:0] exp_res;
      exp_res = pack4(32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      issue(SRA, pack4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
            pack4(31, 31, 31, 31), 4'b0101);
      tick();
      checks++; if (alu_res_o !== exp_res) begin failures++; $display("FAIL sra_res got=%h exp=%h", alu_res_o, exp_res); end
      checks++; if ({cond_o, zero_o, negative_o, overflow_o} !== {4'b0, 4'b0, 4'b0101, 4'b0}) begin failures++;
         $display("FAIL sra_flags got=%h exp=0050", {cond_o, zero_o, negative_o, overflow_o}); end
      tick();
   endtask

   typedef struct {
      string           name;
      logic [3:0]      op;
      logic [L*DW-1:0] a;
      logic [L*DW-1:0] b;
      logic [L-1:0]    m;
      logic [L*DW-1:0] res;
      logic [L-1:0]    cond;
      logic [L-1:0]    zero;
      logic [L-1:0]    neg;
      logic [L-1:0]    ovf;
   } vec_t;

   task automatic test_ops();
      vec_t v[$];
      v.push_back('{"sll", SLL, pack4(1, 1, 1, 1), pack4(0, 4, 31, 33), 4'hF,
                    pack4(1, 32'h10, 32'h80000000, 2), 4'b0, 4'b0, 4'b0100, 4'b0});
      v.push_back('{"sltu", SLTU, pack4(32'hFFFFFFFF, 1, 2, 0), pack4(1, 32'hFFFFFFFF, 2, 0), 4'hF,
                    pack4(0, 1, 0, 0), 4'b0, 4'b1101, 4'b0, 4'b0});
      v.push_back('{"slt", SLT, pack4(32'hFFFFFFFF, 1, 32'h80000000, 7), pack4(0, 32'hFFFFFFFF, 32'h7FFFFFFF, 7), 4'hF,
                    pack4(1, 0, 1, 0), 4'b0, 4'b1010, 4'b0, 4'b0});
      v.push_back('{"bne", BNE, pack4(5, 7, 0, 9), pack4(5, 6, 0, 10), 4'hF,
                    pack4(0, 1, 0, 32'hFFFFFFFF), 4'b1010, 4'b1010, 4'b1000, 4'b0});
      v.push_back('{"bgeu", BGEU, pack4(0, 5, 32'hFFFFFFFF, 3), pack4(1, 5, 0, 4), 4'hF,
                    pack4(0, 1, 1, 0), 4'b0110, 4'b0110, 4'b0, 4'b0});
      v.push_back('{"srl", SRL, pack4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000),
                    pack4(31, 31, 31, 31), 4'hF, pack4(1, 1, 1, 1), 4'b0, 4'b0, 4'b0, 4'b0});
      v.push_back('{"and", AND, pack4(32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0),
                    pack4(32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F), 4'hF,
                    '0, 4'b0, 4'b1111, 4'b0, 4'b0});
`ifdef VALU_PIPE_SAT_EN
      v.push_back('{"sub_ovf", SUB, pack4(32'h80000000, 5, 32'h12345678, 0), pack4(1, 3, 0, 0), 4'b0011,
                    pack4(32'h80000000, 2, 32'h12345678, 0), 4'b0, 4'b0, 4'b0001, 4'b0001});
      v.push_back('{"add_mix", ADD, pack4(32'hFFFFFFFF, 10, 32'h80000000, 0), pack4(1, 20, 32'hFFFFFFFF, 0), 4'hF,
                    pack4(0, 30, 32'h80000000, 0), 4'b0, 4'b1001, 4'b0100, 4'b0100});
`else
      v.push_back('{"sub_ovf", SUB, pack4(32'h80000000, 5, 32'h12345678, 0), pack4(1, 3, 0, 0), 4'b0011,
                    pack4(32'h7FFFFFFF, 2, 32'h12345678, 0), 4'b0, 4'b0, 4'b0000, 4'b0001});
      v.push_back('{"add_mix", ADD, pack4(32'hFFFFFFFF, 10, 32'h80000000, 0), pack4(1, 20, 32'hFFFFFFFF, 0), 4'hF,
                    pack4(0, 30, 32'h7FFFFFFF, 0), 4'b0, 4'b1001, 4'b0000, 4'b0100});
`endif
      foreach (v[i]) begin
         issue(v[i].op, v[i].a, v[i].b, v[i].m);
         tick();
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b exp=1", v[i].name, out_valid); end
         checks++; if (alu_res_o !== v[i].res) begin failures++; $display("FAIL %s_res got=%h exp=%h", v[i].name, alu_res_o, v[i].res); end
         checks++; if ({cond_o, zero_o, negative_o, overflow_o} !== {v[i].cond, v[i].zero, v[i].neg, v[i].ovf}) begin failures++;
            $display("FAIL %s_flags cond/zero/neg/ovf got=%b exp=%b", v[i].name,
                     {cond_o, zero_o, negative_o, overflow_o}, {v[i].cond, v[i].zero, v[i].neg, v[i].ovf}); end
         tick();
         exp_ovf += $countones(v[i].ovf);
         checks++; if (ovf_count_o !== 16'(exp_ovf)) begin failures++; $display("FAIL %s_ovf_count got=%0d exp=%0d", v[i].name, ovf_count_o, exp_ovf); end
      end
   endtask

   // Eight SUB bundles, one per cycle; results expected in cycles 2..9.
   task automatic test_back_to_back();
      logic [L*DW-1:0] exp_res;
      out_ready = 1'b1;
      for (int cyc = 0; cyc <= 10; cyc++) begin
         if (cyc >= 2 && cyc <= 9) begin
            exp_res = pack4(32'(1000 + 15*(cyc-2)), 32'(1001 + 15*(cyc-2)),
                            32'(1002 + 15*(cyc-2)), 32'(1003 + 15*(cyc-2)));
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=1", cyc, out_valid); end
            checks++; if (alu_res_o !== exp_res) begin failures++; $display("FAIL stream_res cyc=%0d got=%h exp=%h", cyc, alu_res_o, exp_res); end
         end else begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle cyc=%0d got=%b exp=0", cyc, out_valid); end
         end
         if (cyc < 8) begin
            alu_op_in   = SUB;
            rs1_data_i  = pack4(32'(1000 + 16*cyc), 32'(1001 + 16*cyc), 32'(1002 + 16*cyc), 32'(1003 + 16*cyc));
            rs2_data_i  = pack4(32'(cyc), 32'(cyc), 32'(cyc), 32'(cyc));
            lane_mask_i = 4'hF;
            in_valid    = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
   endtask

   // Fill both stages, stall 5 cycles, then drain four bundles in order.
   task automatic test_stall();
      logic [L*DW-1:0] exp_q[$];
      logic [L*DW-1:0] exp_res;
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      while (recv < 4 && cyc < 40) begin
         out_ready = (cyc >= 7);
         in_valid  = (sent < 4);
         alu_op_in = ADD;
         rs1_data_i  = pack4(32'(256*sent), 32'(256*sent + 1), 32'(256*sent + 2), 32'(256*sent + 3));
         rs2_data_i  = pack4(32'h10, 32'h10, 32'h10, 32'h10);
         lane_mask_i = 4'hF;
         #1;
         if (cyc >= 2 && cyc <= 6) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", cyc, out_valid); end
            checks++; if (alu_res_o !== pack4(32'h10, 32'h11, 32'h12, 32'h13)) begin failures++;
               $display("FAIL stall_hold cyc=%0d got=%h", cyc, alu_res_o); end
         end
         if (out_valid && out_ready) begin
            exp_res = pack4(32'(256*recv + 16), 32'(256*recv + 17), 32'(256*recv + 18), 32'(256*recv + 19));
            checks++; if (alu_res_o !== exp_res) begin failures++; $display("FAIL drain_res idx=%0d got=%h exp=%h", recv, alu_res_o, exp_res); end
            recv++;
         end
         if (in_valid && in_ready) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (recv != 4) begin failures++; $display("FAIL drain_count got=%0d exp=4", recv); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_extra got=%b exp=0", out_valid); end
   endtask

   // Accept one overflowing bundle, then hit reset on the cycle a second is
   // being presented; neither may emerge or be counted.
   task automatic test_reset_mid();
      out_ready   = 1'b1;
      alu_op_in   = ADD;
      rs1_data_i  = pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
      rs2_data_i  = pack4(1, 1, 1, 1);
      lane_mask_i = 4'hF;
      in_valid    = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
      checks++; if (alu_res_o !== '0) begin failures++; $display("FAIL rstmid_res got=%h exp=0", alu_res_o); end
      checks++; if (ovf_count_o !== 16'h0) begin failures++; $display("FAIL rstmid_ovf_count got=%0d exp=0", ovf_count_o); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid cyc=%0d got=%b exp=0", i, out_valid); end
         tick();
      end
      checks++; if (ovf_count_o !== 16'h0) begin failures++; $display("FAIL rstmid_ovf_after got=%0d exp=0", ovf_count_o); end
      exp_ovf = 0;
   endtask

   // 16400 bundles x 4 overflowing lanes would wrap a 16-bit counter.
   task automatic test_ovf_saturate();
      out_ready   = 1'b1;
      alu_op_in   = ADD;
      rs1_data_i  = pack4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
      rs2_data_i  = pack4(1, 1, 1, 1);
      lane_mask_i = 4'hF;
      in_valid    = 1'b1;
      for (int i = 0; i < 16400; i++) tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      checks++; if (ovf_count_o !== 16'hFFFF) begin failures++; $display("FAIL ovf_saturate got=%h exp=ffff", ovf_count_o); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_blt();
      test_sra();
      test_ops();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_ovf_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
